// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle controller: state codes, opcodes and
// datapath select encodings.
package multicycle_control_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXEC     = 4'd2,
      S_MEM_ADDR = 4'd3,
      S_MEM_RD   = 4'd4,
      S_MEM_WB   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_ALU_WB   = 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9
   } state_e;

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   typedef enum logic [1:0] {
      ASEL_PC    = 2'd0,
      ASEL_OLDPC = 2'd1,
      ASEL_RS1   = 2'd2
   } alu_sel_a_e;

   typedef enum logic [1:0] {
      BSEL_RS2  = 2'd0,
      BSEL_IMM  = 2'd1,
      BSEL_FOUR = 2'd2
   } alu_sel_b_e;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'd0,
      ALUOP_SUB   = 2'd1,
      ALUOP_FUNCT = 2'd2
   } alu_op_e;

   typedef enum logic [1:0] {
      PCSRC_ALU    = 2'd0,
      PCSRC_ALUOUT = 2'd1
   } pc_src_e;

   typedef enum logic [1:0] {
      WB_ALUOUT = 2'd0,
      WB_MEM    = 2'd1,
      WB_PC     = 2'd2
   } wb_sel_e;

   // Dispatch target out of DECODE; FETCH here means the opcode is illegal.
   function automatic state_e decode_next(input logic [6:0] op);
      case (op)
         OP_RTYPE, OP_ITYPE: decode_next = S_EXEC;
         OP_LOAD, OP_STORE:  decode_next = S_MEM_ADDR;
         OP_BRANCH:          decode_next = S_BRANCH;
         OP_JAL, OP_JALR:    decode_next = S_JUMP;
         default:            decode_next = S_FETCH;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_control_retire_counter.sv
// Wrapping count of retired instructions.
module retire_counter #(
   parameter int unsigned W = 32
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         inc_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i) count_d = count_q + W'(1);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) count_q <= '0;
      else       count_q <= count_d;
   end

   assign count_o = count_q;

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V style main controller: FETCH/DECODE dispatch FSM driving
// datapath selects, memory handshake and a retired-instruction counter.
module multicycle_control
   import multicycle_control_pkg::*;
#(
   parameter int unsigned RETIRE_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [6:0]          opcode_i,
   input  logic [2:0]          func3_i,
   input  logic                branch_flag_i,
   input  logic                mem_ready_i,
   output logic                mem_req_o,
   output logic                mem_we_o,
   output logic                iord_o,
   output logic                ir_write_o,
   output logic                pc_write_o,
   output logic                reg_write_o,
   output logic                branch_o,
   output logic                illegal_o,
   output logic [1:0]          alu_sel_a_o,
   output logic [1:0]          alu_sel_b_o,
   output logic [1:0]          alu_op_o,
   output logic [1:0]          pc_src_o,
   output logic [1:0]          wb_sel_o,
   output logic [3:0]          state_o,
   output logic [RETIRE_W-1:0] retired_o
);

   state_e     state_q, state_d;
   logic       mem_req, mem_we, iord, ir_write, pc_write, reg_write;
   logic       branch, illegal, retire;
   alu_sel_a_e asel;
   alu_sel_b_e bsel;
   alu_op_e    aop;
   pc_src_e    psrc;
   wb_sel_e    wsel;

   // funct3 passes through the instruction register untouched by this block.
   logic unused_func3;
   assign unused_func3 = ^func3_i;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d   = S_FETCH;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      iord      = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
      branch    = 1'b0;
      illegal   = 1'b0;
      retire    = 1'b0;
      asel      = ASEL_PC;
      bsel      = BSEL_RS2;
      aop       = ALUOP_ADD;
      psrc      = PCSRC_ALU;
      wsel      = WB_ALUOUT;
      case (state_q)
         S_FETCH: begin
            mem_req  = 1'b1;
            bsel     = BSEL_FOUR;
            ir_write = mem_ready_i;
            pc_write = mem_ready_i;
            state_d  = mem_ready_i ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            asel    = ASEL_OLDPC;
            bsel    = BSEL_IMM;
            state_d = decode_next(opcode_i);
            illegal = (state_d == S_FETCH);
         end
         S_EXEC: begin
            asel    = ASEL_RS1;
            aop     = ALUOP_FUNCT;
            bsel    = (opcode_i == OP_RTYPE) ? BSEL_RS2 : BSEL_IMM;
            state_d = S_ALU_WB;
         end
         S_ALU_WB: begin
            reg_write = 1'b1;
            wsel      = WB_ALUOUT;
            retire    = 1'b1;
         end
         S_MEM_ADDR: begin
            asel    = ASEL_RS1;
            bsel    = BSEL_IMM;
            state_d = (opcode_i == OP_STORE) ? S_MEM_WR : S_MEM_RD;
         end
         S_MEM_RD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            state_d = mem_ready_i ? S_MEM_WB : S_MEM_RD;
         end
         S_MEM_WR: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            iord    = 1'b1;
            retire  = mem_ready_i;
            state_d = mem_ready_i ? S_FETCH : S_MEM_WR;
         end
         S_MEM_WB: begin
            reg_write = 1'b1;
            wsel      = WB_MEM;
            retire    = 1'b1;
         end
         S_BRANCH: begin
            branch   = 1'b1;
            asel     = ASEL_RS1;
            bsel     = BSEL_RS2;
            aop      = ALUOP_SUB;
            psrc     = PCSRC_ALUOUT;
            pc_write = branch_flag_i;
            retire   = 1'b1;
         end
         S_JUMP: begin
            branch    = 1'b1;
            reg_write = 1'b1;
            wsel      = WB_PC;
            pc_write  = 1'b1;
            asel      = ASEL_RS1;
            bsel      = BSEL_IMM;
            psrc      = (opcode_i == OP_JAL) ? PCSRC_ALUOUT : PCSRC_ALU;
            retire    = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase
   end

   retire_counter #(.W(RETIRE_W)) u_retire (
      .clk_i   (clk),
      .rst_i   (reset),
      .inc_i   (retire),
      .count_o (retired_o)
   );

   // Write enables are masked by reset itself since FETCH would otherwise
   // pass mem_ready_i straight through while reset is held.
   assign mem_req_o   = mem_req;
   assign mem_we_o    = mem_we & ~reset;
   assign iord_o      = iord;
   assign ir_write_o  = ir_write & ~reset;
   assign pc_write_o  = pc_write & ~reset;
   assign reg_write_o = reg_write & ~reset;
   assign branch_o    = branch;
   assign illegal_o   = illegal;
   assign alu_sel_a_o = asel;
   assign alu_sel_b_o = bsel;
   assign alu_op_o    = aop;
   assign pc_src_o    = psrc;
   assign wb_sel_o    = wsel;
   assign state_o     = state_q;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter RETIRE_W, default 32, width of the retired-instruction counter.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port opcode_i, input, 7, opcode field of the instruction register.
REQ-005 SHALL have port func3_i, input, 3, funct3 field of the instruction register (forwarded only; not decoded here).
REQ-006 SHALL have port branch_flag_i, input, 1, taken flag returned by the branch comparator.
REQ-007 SHALL have port mem_ready_i, input, 1, memory completion handshake.
REQ-008 SHALL have outputs, each 1 bit: mem_req_o, mem_we_o, iord_o (0 = instruction address, 1 = data address), ir_write_o, pc_write_o, reg_write_o, branch_o (drives the comparator Branch_i), illegal_o.
REQ-009 SHALL have outputs, each 2 bits: alu_sel_a_o (0 = PC, 1 = old PC, 2 = rs1), alu_sel_b_o (0 = rs2, 1 = imm, 2 = const 4), alu_op_o (0 = add, 1 = sub, 2 = funct-decoded), pc_src_o (0 = ALU result, 1 = ALUOut register), wb_sel_o (0 = ALUOut, 1 = memory data, 2 = PC).
REQ-010 SHALL have outputs state_o, 4 bits, current state; retired_o, RETIRE_W bits, count of completed instructions.

Function
REQ-011 SHALL implement the states FETCH=0, DECODE=1, EXEC=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, ALU_WB=7, BRANCH=8, JUMP=9; codes 10 to 15 SHALL go to FETCH on the next cycle.
REQ-012 All outputs SHALL be 0 unless a state below asserts them.
REQ-013 FETCH: mem_req=1, iord=0, alu_sel_a=0, alu_sel_b=2, alu_op=0, pc_src=0; ir_write and pc_write SHALL equal mem_ready_i; stay in FETCH until mem_ready_i=1, then go to DECODE.
REQ-014 DECODE: alu_sel_a=1, alu_sel_b=1, alu_op=0 (branch/JAL target to ALUOut); next state by opcode_i:
- 0110011 or 0010011 -> EXEC
- 0000011 or 0100011 -> MEM_ADDR
- 1100011 -> BRANCH
- 1101111 or 1100111 -> JUMP
- any other opcode -> FETCH, with illegal_o=1 for that one cycle and no retire.
REQ-015 EXEC: alu_sel_a=2, alu_op=2, alu_sel_b=0 for R-type (0110011) and 1 for I-type; go to ALU_WB.
REQ-016 ALU_WB: reg_write=1, wb_sel=0; go to FETCH.
REQ-017 MEM_ADDR: alu_sel_a=2, alu_sel_b=1, alu_op=0; go to MEM_RD for loads, MEM_WR for stores.
REQ-018 MEM_RD and MEM_WR: mem_req=1, iord=1; mem_we=1 in MEM_WR only; hold the state while mem_ready_i=0; on ready, MEM_RD goes to MEM_WB and MEM_WR goes to FETCH.
REQ-019 MEM_WB: reg_write=1, wb_sel=1; go to FETCH.
REQ-020 BRANCH: branch_o=1, alu_sel_a=2, alu_sel_b=0, alu_op=1, pc_src=1, pc_write=branch_flag_i; go to FETCH.
REQ-021 JUMP: branch_o=1, reg_write=1, wb_sel=2, pc_write=1, alu_sel_a=2, alu_sel_b=1, alu_op=0; pc_src=1 for JAL and 0 for JALR; go to FETCH.
REQ-022 Every transition into FETCH from ALU_WB, MEM_WB, MEM_WR, BRANCH or JUMP SHALL increment retired_o by 1, wrapping modulo 2^RETIRE_W.
REQ-023 Instruction latency, with zero memory wait: ALU 4 cycles, load 5, store 4, branch 3, jump 3; each wait cycle adds one.
REQ-024 mem_ready_i SHALL be ignored outside FETCH, MEM_RD and MEM_WR.

Reset
REQ-025 reset=1 SHALL immediately force the state to FETCH and retired_o to 0, including mid-wait in MEM_RD or MEM_WR.
REQ-026 During reset, pc_write, ir_write, reg_write and mem_we SHALL be 0.
REQ-027 The first FETCH SHALL begin on the first clock edge after reset deasserts.

Structure
REQ-028 A shared package SHALL hold the state codes, opcode constants and the alu_sel, alu_op, pc_src and wb_sel encodings.
REQ-029 The retired-instruction counter SHALL be one sub-module, retire_counter.

Verification
REQ-030 reset mid-MEM_RD with mem_ready_i=0 -> state_o=0 and retired_o=0 immediately; FETCH restarts after reset release.
REQ-031 opcode 0110011, mem_ready_i always 1 -> states 0,1,2,7,0; reg_write=1 only in state 7; retired_o +1.
REQ-032 load with mem_ready_i=0 for 3 cycles in MEM_RD -> 8 cycles total; mem_req held high throughout; wb_sel=1 in MEM_WB.
REQ-033 opcode 1100011 with branch_flag_i=0, then =1 -> pc_write=0, then =1 in state 8; branch_o=1 in both cases.
REQ-034 opcode 1100111 -> state 9 with pc_src=0, wb_sel=2, pc_write=1; opcode 1101111 -> pc_src=1.
REQ-035 opcode 0000000 -> illegal_o pulses for one cycle in DECODE, returns to FETCH, retired_o unchanged; with RETIRE_W=4, 16 retires wrap retired_o to 0.
